// File: rtl/pm_access_arb.sv
// pm_access_arb
// Arbiter and sequencer for the single-port program memory (PM).
// The CPU fetch path owns the PM port by default. A loader/debug port can
// borrow it for bounded bursts. The CPU is stalled while the loader owns the port.
//
// Optional feature macro: PM_ARB_WPROT_EN
//   When it is defined, a loader write at or above PROT_BASE is refused.
//   A refused write is still acknowledged, with ldr_err_o=1.
//
// Ports
//   clk_i, rst_i   clock; asynchronous active-high reset
//   cpu_addr_i     CPU fetch address, held by the CPU while stalled
//   cpu_stall_o    CPU must freeze fetch/PC
//   ldr_req_i      loader request, held until ldr_ack_o
//   ldr_we_i       loader direction (1 = write)
//   ldr_addr_i     loader word address
//   ldr_data_i     loader write data
//   ldr_ack_o      one-cycle completion pulse
//   ldr_err_o      with ack: the write was refused
//   ldr_data_o     registered read data, updated at the end of the ack cycle
//   pm_addr_o      PM address
//   pm_we_o        PM write enable
//   pm_data_o      PM write data
//   pm_data_i      PM read data, valid one cycle after the address edge
//   dbg_state_o    current FSM state (debug observation)
//
// Loader handshake
//   The loader raises ldr_req_i with stable ldr_we_i, ldr_addr_i and ldr_data_i.
//   It keeps them stable until it sees ldr_ack_o. An access completes on the
//   single cycle in which ldr_ack_o=1.
//   In the following WAIT cycle the loader can either:
//     - present the next request, which continues the burst, or
//     - drop ldr_req_i.
//   Dropping the request before the ack is not supported.

module pm_access_arb #(
  parameter int ADDR_W    = 13,
  parameter int WORD_SIZE = 16,
  parameter int MAX_BURST = 8,
  parameter int PROT_BASE = 1720
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  output logic                 cpu_stall_o,
  input  logic                 ldr_req_i,
  input  logic                 ldr_we_i,
  input  logic [ADDR_W-1:0]    ldr_addr_i,
  input  logic [WORD_SIZE-1:0] ldr_data_i,
  output logic                 ldr_ack_o,
  output logic                 ldr_err_o,
  output logic [WORD_SIZE-1:0] ldr_data_o,
  output logic [ADDR_W-1:0]    pm_addr_o,
  output logic                 pm_we_o,
  output logic [WORD_SIZE-1:0] pm_data_o,
  input  logic [WORD_SIZE-1:0] pm_data_i,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCESS  = 3'd1,
    S_DONE    = 3'd2,
    S_WAIT    = 3'd3,
    S_RESTORE = 3'd4
  } state_t;

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_t               r_state;
  state_t               w_next;
  logic [7:0]           r_burst;
  logic                 r_guard;
  logic [WORD_SIZE-1:0] r_rdata;
  logic                 w_prot;
  logic                 w_ldr_owns;

`ifdef PM_ARB_WPROT_EN
  localparam logic [ADDR_W-1:0] PROT_BASE_A = ADDR_W'(PROT_BASE);
  logic r_err;

  // Only writes into the bootloader region are refused.
  assign w_prot = ldr_we_i && (ldr_addr_i >= PROT_BASE_A);

  // Capture the refusal during ACCESS so that it is reported with the ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (r_state == S_ACCESS) begin
      r_err <= w_prot;
    end
  end

  assign ldr_err_o = (r_state == S_DONE) && r_err;
`else
  assign w_prot    = 1'b0;
  assign ldr_err_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (ldr_req_i && !r_guard) w_next = S_ACCESS;
      S_ACCESS:  w_next = S_DONE;
      S_DONE:    w_next = S_WAIT;
      S_WAIT:    w_next = (ldr_req_i && (r_burst < BURST_MAX)) ? S_ACCESS : S_RESTORE;
      S_RESTORE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Burst counter, guard and read-data capture.
  // The guard is set by RESTORE and holds off a grant for one IDLE cycle.
  // This gives the CPU at least one unstalled fetch between two loader grants.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_burst <= '0;
      r_guard <= 1'b0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_guard <= 1'b0;
          if (ldr_req_i && !r_guard) r_burst <= '0;
        end
        S_DONE: begin
          r_burst <= r_burst + 8'd1;
          r_rdata <= pm_data_i;
        end
        S_RESTORE: r_guard <= 1'b1;
        default: ;
      endcase
    end
  end

  // The loader address is presented from ACCESS through WAIT.
  // In RESTORE the port switches back to the CPU address while the stall is
  // still high. The PM then re-reads the CPU's held fetch, and that data is
  // valid in the first IDLE cycle.
  assign w_ldr_owns = (r_state == S_ACCESS) || (r_state == S_DONE) || (r_state == S_WAIT);
  assign pm_addr_o  = w_ldr_owns ? ldr_addr_i : cpu_addr_i;

  // Gating with rst_i removes the write enable combinationally as soon as
  // reset asserts.
  assign pm_we_o     = (r_state == S_ACCESS) && ldr_we_i && !w_prot && !rst_i;
  assign pm_data_o   = ldr_data_i;
  assign cpu_stall_o = (r_state != S_IDLE);
  assign ldr_ack_o   = (r_state == S_DONE);
  assign ldr_data_o  = r_rdata;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pm_access_arb.sv
module tb_pm_access_arb;

  logic        clk_i;
  logic        rst_i;
  logic [12:0] cpu_addr_i;
  logic        cpu_stall_o;
  logic        ldr_req_i;
  logic        ldr_we_i;
  logic [12:0] ldr_addr_i;
  logic [15:0] ldr_data_i;
  logic        ldr_ack_o;
  logic        ldr_err_o;
  logic [15:0] ldr_data_o;
  logic [12:0] pm_addr_o;
  logic        pm_we_o;
  logic [15:0] pm_data_o;
  logic [15:0] pm_data_i;
  logic [2:0]  dbg_state_o;

`ifdef PM_ARB_WPROT_EN
  localparam logic WPROT = 1'b1;
`else
  localparam logic WPROT = 1'b0;
`endif

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACCESS  = 3'd1;
  localparam logic [2:0] ST_RESTORE = 3'd4;

  pm_access_arb dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_stall_o (cpu_stall_o),
    .ldr_req_i   (ldr_req_i),
    .ldr_we_i    (ldr_we_i),
    .ldr_addr_i  (ldr_addr_i),
    .ldr_data_i  (ldr_data_i),
    .ldr_ack_o   (ldr_ack_o),
    .ldr_err_o   (ldr_err_o),
    .ldr_data_o  (ldr_data_o),
    .pm_addr_o   (pm_addr_o),
    .pm_we_o     (pm_we_o),
    .pm_data_o   (pm_data_o),
    .pm_data_i   (pm_data_i),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // PM model: the address is registered, and reads return the old data
  // (read-first).
  logic [15:0] mem [0:8191];
  always @(posedge clk_i) begin
    if (pm_we_o === 1'b1) mem[pm_addr_o] <= pm_data_o;
    pm_data_i <= mem[pm_addr_o];
  end

  function automatic logic [15:0] init_val(input logic [12:0] a);
    return 16'h5A00 ^ {3'b000, a};
  endfunction

  // Bus observation counters
  int          we_cnt = 0;
  int          ack_cnt = 0;
  int          free_cnt = 0;
  int          restore_log[$];
  logic [12:0] last_we_addr = '0;
  logic [15:0] refetch_val = '0;
  logic [2:0]  prev_state = '0;
  always @(posedge clk_i) begin
    if (pm_we_o === 1'b1) begin
      we_cnt++;
      last_we_addr = pm_addr_o;
    end
    if (ldr_ack_o === 1'b1) ack_cnt++;
    if (ldr_req_i && cpu_stall_o === 1'b0) free_cnt++;
    if (dbg_state_o == ST_RESTORE) restore_log.push_back(ack_cnt);
    if (prev_state == ST_RESTORE && dbg_state_o == ST_IDLE) refetch_val = pm_data_i;
    prev_state = dbg_state_o;
  end

  // Driver: called 2 time units after a rising edge. Presents one loader
  // access and waits, with a bound, for the ack. Returns in the cycle after
  // the ack, 2 time units after its edge.
  task automatic ldr_xfer(input logic we, input logic [12:0] addr, input logic [15:0] data,
                          input logic keep, output logic ok, output logic err, output int lat);
    ldr_req_i = 1'b1; ldr_we_i = we; ldr_addr_i = addr; ldr_data_i = data;
    ok = 1'b0; err = 1'b0; lat = -1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ldr_ack_o === 1'b1) begin ok = 1'b1; err = ldr_err_o; lat = c; end
      @(posedge clk_i); #2;
      if (ok) break;
    end
    if (!keep) begin ldr_req_i = 1'b0; ldr_we_i = 1'b0; end
  endtask

  task automatic settle();
    repeat (4) begin @(posedge clk_i); #2; end
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (cpu_stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b exp 0", cpu_stall_o); end
    n_vec++; if (ldr_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b exp 0", ldr_ack_o); end
    n_vec++; if (ldr_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b exp 0", ldr_err_o); end
    n_vec++; if (ldr_data_o !== 16'h0) begin n_err++; $display("FAIL reset_rdata: got %h exp 0000", ldr_data_o); end
    n_vec++; if (pm_we_o !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b exp 0", pm_we_o); end
    n_vec++; if (dbg_state_o !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d exp 0", dbg_state_o); end
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 16; a++) begin
      cpu_addr_i = 13'(a);
      #1;
      n_vec++; if (pm_addr_o !== 13'(a)) begin n_err++; $display("FAIL sweep_addr: got %h exp %h", pm_addr_o, 13'(a)); end
      n_vec++; if (cpu_stall_o !== 1'b0) begin n_err++; $display("FAIL sweep_stall: got %b exp 0", cpu_stall_o); end
      n_vec++; if (pm_we_o !== 1'b0) begin n_err++; $display("FAIL sweep_we: got %b exp 0", pm_we_o); end
      @(posedge clk_i); #2;
    end
  endtask

  task automatic test_write();
    int we0; logic ok; logic err; int lat; logic [15:0] e;
    settle();
    we0 = we_cnt;
    cpu_addr_i = 13'h040;
    ldr_req_i = 1'b1; ldr_we_i = 1'b1; ldr_addr_i = 13'h010; ldr_data_i = 16'hA5C3;
    #1;
    n_vec++; if (cpu_stall_o !== 1'b0) begin n_err++; $display("FAIL wr_stall_req: got %b exp 0", cpu_stall_o); end
    @(posedge clk_i); #3;
    n_vec++; if (cpu_stall_o !== 1'b1) begin n_err++; $display("FAIL wr_stall_access: got %b exp 1", cpu_stall_o); end
    n_vec++; if (pm_we_o !== 1'b1) begin n_err++; $display("FAIL wr_we_access: got %b exp 1", pm_we_o); end
    n_vec++; if (pm_addr_o !== 13'h010) begin n_err++; $display("FAIL wr_addr_access: got %h exp 0010", pm_addr_o); end
    n_vec++; if (pm_data_o !== 16'hA5C3) begin n_err++; $display("FAIL wr_pm_data: got %h exp a5c3", pm_data_o); end
    n_vec++; if (ldr_ack_o !== 1'b0) begin n_err++; $display("FAIL wr_early_ack: got %b exp 0", ldr_ack_o); end
    @(posedge clk_i); #3;
    n_vec++; if (ldr_ack_o !== 1'b1) begin n_err++; $display("FAIL wr_ack: got %b exp 1", ldr_ack_o); end
    n_vec++; if (ldr_err_o !== 1'b0) begin n_err++; $display("FAIL wr_err: got %b exp 0", ldr_err_o); end
    n_vec++; if (pm_we_o !== 1'b0) begin n_err++; $display("FAIL wr_we_done: got %b exp 0", pm_we_o); end
    @(posedge clk_i); #2;
    ldr_req_i = 1'b0; ldr_we_i = 1'b0;
    n_vec++; if (we_cnt - we0 !== 1) begin n_err++; $display("FAIL wr_pulses: got %0d exp 1", we_cnt - we0); end
    n_vec++; if (last_we_addr !== 13'h010) begin n_err++; $display("FAIL wr_pulse_addr: got %h exp 0010", last_we_addr); end
    exp_q.push_back(16'hA5C3);
    ldr_xfer(1'b0, 13'h010, 16'h0, 1'b0, ok, err, lat);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rd_timeout: got %b exp 1", ok); end
    e = exp_q.pop_front();
    n_vec++; if (ldr_data_o !== e) begin n_err++; $display("FAIL rd_back: got %h exp %h", ldr_data_o, e); end
  endtask

  task automatic test_burst();
    int a0; int r0; int f0; int f1; logic ok; logic err; int lat;
    logic [12:0] a; logic [15:0] e;
    settle();
    cpu_addr_i = 13'h123;
    a0 = ack_cnt; r0 = restore_log.size(); f0 = 0; f1 = 0;
    for (int i = 0; i < 12; i++) begin
      a = 13'h200 + 13'(i);
      exp_q.push_back(init_val(a));
      ldr_xfer(1'b0, a, 16'h0, (i != 11), ok, err, lat);
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL burst_timeout: idx %0d got %b exp 1", i, ok); end
      e = exp_q.pop_front();
      n_vec++; if (ldr_data_o !== e) begin n_err++; $display("FAIL burst_rdata: idx %0d got %h exp %h", i, ldr_data_o, e); end
      if (i == 7) f0 = free_cnt;
      if (i == 8) f1 = free_cnt;
    end
    settle();
    n_vec++; if (ack_cnt - a0 !== 12) begin n_err++; $display("FAIL burst_acks: got %0d exp 12", ack_cnt - a0); end
    n_vec++; if (restore_log.size() - r0 !== 2) begin n_err++; $display("FAIL burst_restores: got %0d exp 2", restore_log.size() - r0); end
    if (restore_log.size() > r0) begin
      n_vec++; if (restore_log[r0] - a0 !== 8) begin n_err++; $display("FAIL burst_first_grant: got %0d exp 8", restore_log[r0] - a0); end
    end
    n_vec++; if (f1 - f0 < 1) begin n_err++; $display("FAIL burst_cpu_gap: got %0d exp >=1", f1 - f0); end
    n_vec++; if (refetch_val !== init_val(13'h123)) begin n_err++; $display("FAIL burst_refetch: got %h exp %h", refetch_val, init_val(13'h123)); end
  endtask

  task automatic test_wprot();
    int we0; logic ok; logic err; int lat; logic [15:0] e;
    settle();
    we0 = we_cnt;
    ldr_xfer(1'b1, 13'h06B8, 16'h1111, 1'b0, ok, err, lat);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL wprot_hi_ack: got %b exp 1", ok); end
    n_vec++; if (err !== WPROT) begin n_err++; $display("FAIL wprot_hi_err: got %b exp %b", err, WPROT); end
    n_vec++; if (we_cnt - we0 !== (WPROT ? 0 : 1)) begin n_err++; $display("FAIL wprot_hi_we: got %0d exp %0d", we_cnt - we0, (WPROT ? 0 : 1)); end
    we0 = we_cnt;
    ldr_xfer(1'b1, 13'h06B7, 16'h2222, 1'b0, ok, err, lat);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL wprot_lo_ack: got %b exp 1", ok); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL wprot_lo_err: got %b exp 0", err); end
    n_vec++; if (we_cnt - we0 !== 1) begin n_err++; $display("FAIL wprot_lo_we: got %0d exp 1", we_cnt - we0); end
    exp_q.push_back(WPROT ? init_val(13'h06B8) : 16'h1111);
    ldr_xfer(1'b0, 13'h06B8, 16'h0, 1'b0, ok, err, lat);
    e = exp_q.pop_front();
    n_vec++; if (ldr_data_o !== e) begin n_err++; $display("FAIL wprot_hi_rd: got %h exp %h", ldr_data_o, e); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL wprot_rd_err: got %b exp 0", err); end
    exp_q.push_back(16'h2222);
    ldr_xfer(1'b0, 13'h06B7, 16'h0, 1'b0, ok, err, lat);
    e = exp_q.pop_front();
    n_vec++; if (ldr_data_o !== e) begin n_err++; $display("FAIL wprot_lo_rd: got %h exp %h", ldr_data_o, e); end
  endtask

  task automatic test_reset_mid();
    int we0; int a0; logic ok; logic err; int lat; logic [15:0] e;
    settle();
    we0 = we_cnt; a0 = ack_cnt;
    ldr_req_i = 1'b1; ldr_we_i = 1'b1; ldr_addr_i = 13'h0300; ldr_data_i = 16'hBEEF;
    @(posedge clk_i); #3;
    n_vec++; if (pm_we_o !== 1'b1) begin n_err++; $display("FAIL rstmid_we_pre: got %b exp 1", pm_we_o); end
    #1 rst_i = 1'b1;
    #1;
    n_vec++; if (pm_we_o !== 1'b0) begin n_err++; $display("FAIL rstmid_we_drop: got %b exp 0", pm_we_o); end
    n_vec++; if (dbg_state_o !== ST_IDLE) begin n_err++; $display("FAIL rstmid_state: got %0d exp 0", dbg_state_o); end
    n_vec++; if (cpu_stall_o !== 1'b0) begin n_err++; $display("FAIL rstmid_stall: got %b exp 0", cpu_stall_o); end
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    n_vec++; if (ack_cnt - a0 !== 0) begin n_err++; $display("FAIL rstmid_ack: got %0d exp 0", ack_cnt - a0); end
    n_vec++; if (we_cnt - we0 !== 0) begin n_err++; $display("FAIL rstmid_write: got %0d exp 0", we_cnt - we0); end
    ldr_xfer(1'b1, 13'h0300, 16'hBEEF, 1'b0, ok, err, lat);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rstmid_retry_ack: got %b exp 1", ok); end
    n_vec++; if (we_cnt - we0 !== 1) begin n_err++; $display("FAIL rstmid_retry_we: got %0d exp 1", we_cnt - we0); end
    exp_q.push_back(16'hBEEF);
    ldr_xfer(1'b0, 13'h0300, 16'h0, 1'b0, ok, err, lat);
    e = exp_q.pop_front();
    n_vec++; if (ldr_data_o !== e) begin n_err++; $display("FAIL rstmid_rd: got %h exp %h", ldr_data_o, e); end
  endtask

  task automatic test_guard();
    logic ok; logic err; int lat; logic [15:0] e;
    settle();
    cpu_addr_i = 13'h0077;
    exp_q.push_back(init_val(13'h0050));
    ldr_xfer(1'b0, 13'h0050, 16'h0, 1'b0, ok, err, lat);
    e = exp_q.pop_front();
    n_vec++; if (ldr_data_o !== e) begin n_err++; $display("FAIL guard_rd0: got %h exp %h", ldr_data_o, e); end
    @(posedge clk_i); #2;
    n_vec++; if (dbg_state_o !== ST_RESTORE) begin n_err++; $display("FAIL guard_restore: got %0d exp 4", dbg_state_o); end
    n_vec++; if (pm_addr_o !== 13'h0077) begin n_err++; $display("FAIL guard_restore_addr: got %h exp 0077", pm_addr_o); end
    ldr_req_i = 1'b1; ldr_we_i = 1'b0; ldr_addr_i = 13'h0051;
    exp_q.push_back(init_val(13'h0051));
    @(posedge clk_i); #3;
    n_vec++; if (dbg_state_o !== ST_IDLE || cpu_stall_o !== 1'b0) begin n_err++; $display("FAIL guard_idle1: got st %0d stall %b exp 0/0", dbg_state_o, cpu_stall_o); end
    @(posedge clk_i); #3;
    n_vec++; if (dbg_state_o !== ST_IDLE || cpu_stall_o !== 1'b0) begin n_err++; $display("FAIL guard_idle2: got st %0d stall %b exp 0/0", dbg_state_o, cpu_stall_o); end
    @(posedge clk_i); #3;
    n_vec++; if (dbg_state_o !== ST_ACCESS || cpu_stall_o !== 1'b1) begin n_err++; $display("FAIL guard_grant: got st %0d stall %b exp 1/1", dbg_state_o, cpu_stall_o); end
    @(posedge clk_i); #3;
    n_vec++; if (ldr_ack_o !== 1'b1) begin n_err++; $display("FAIL guard_ack: got %b exp 1", ldr_ack_o); end
    @(posedge clk_i); #2;
    ldr_req_i = 1'b0;
    e = exp_q.pop_front();
    n_vec++; if (ldr_data_o !== e) begin n_err++; $display("FAIL guard_rd1: got %h exp %h", ldr_data_o, e); end
    settle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    cpu_addr_i = '0; ldr_req_i = 1'b0; ldr_we_i = 1'b0; ldr_addr_i = '0; ldr_data_i = '0;
    for (int i = 0; i < 8192; i++) mem[i] <= init_val(13'(i));
    repeat (3) @(posedge clk_i);
    #2;
    test_reset();
    rst_i = 1'b0;
    @(posedge clk_i); #2;
    test_sweep();
    test_write();
    test_burst();
    test_wprot();
    test_reset_mid();
    test_guard();
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_left: got %0d exp 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
